operand_unpack_align: RTL and testbench
=======================================

# operand_unpack_align

Front-end stage of the floating-point adder. It accepts two IEEE-754 single-precision operands over a valid/ready handshake and unpacks each into the adder's 28-bit extended-fraction word: sign, reserved carry, hidden bit, 23-bit fraction and 2 guard bits. It then right-shifts the smaller-exponent operand over several cycles until both share the larger exponent. Its output words use the same layout that the rounding/packing stage consumes at the far end of the datapath.

## Interface
Parameters:
- SHIFT_STEP, default 1: magnitude bits shifted per ALIGN cycle; legal range 1..8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- res  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands; high only in IDLE.
- op_a  in  32  operand A, IEEE-754 single precision.
- op_b  in  32  operand B, IEEE-754 single precision.
- out_valid  out  1  aligned result available.
- out_ready  in  1  downstream accepts the result.
- fra_a  out  28  extended word A: [27] sign, [26] reserved 0, [25] hidden, [24:2] fraction, [1:0] guard.
- fra_b  out  28  extended word B, same layout.
- exp_common  out  8  larger of the two biased exponents.
- special  out  1  either operand has exponent 8'hFF (Inf/NaN).

## Operation
- States are IDLE, UNPACK, ALIGN and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid and in_ready are both high, capture op_a and op_b and go to UNPACK.
- UNPACK (1 cycle):
  - Word = {sign, 1'b0, hidden, frac, 2'b00}.
  - hidden = (exp!=0). Exponent 0 is flushed to zero: magnitude bits [25:0]=0, sign kept.
  - exp_common = max(ea, eb).
  - d = |ea-eb|. The operand with the smaller exponent is the one shifted. On a tie, neither is shifted.
  - special=1 → go to DONE, words left unshifted.
  - d=0 → go to DONE.
  - d≥26 → the small word's bits [25:0] are forced to 0 (sticky rule below applies), then go to DONE.
  - Otherwise load remaining=d and go to ALIGN.
- ALIGN:
  - Each cycle, right-shift bits [25:0] of the small word by min(SHIFT_STEP, remaining) and decrement remaining by the same amount.
  - Bit [27] is untouched and bit [26] stays 0.
  - When remaining reaches 0, go to DONE.
- DONE:
  - out_valid=1; all outputs held stable.
  - When out_valid and out_ready are both high, go to IDLE.
- Two zero operands: exp_common=0, both words sign-only.

## Timing
- Reset state: IDLE. in_ready=1, out_valid=0, fra_a=fra_b=0, exp_common=0, special=0, remaining=0.
- Reset mid-operation: the transaction is aborted with no output and the block returns to IDLE.
- Latency from the acceptance edge to out_valid:
  - 2 cycles when d=0, d≥26, or special=1.
  - 2+ceil(d/SHIFT_STEP) cycles otherwise.
- Throughput: one transaction in flight at a time. in_ready=0 from the accept edge until the DONE handshake completes.
- Back-to-back: a new accept is possible in the cycle after the output handshake.
- in_ready is decoded directly from state; in_valid does not combinationally affect any output.

## Configuration
- UNPACK_STICKY_EN defined:
  - Bit [0] of the shifted word becomes the OR of its previous value and every bit shifted out below it.
  - In the d≥26 case, bit [0] = OR of the original small magnitude bits [25:0].
- UNPACK_STICKY_EN undefined: shifted-out bits are discarded (truncation). In the d≥26 case the magnitude is 0.

## Structure
- Shared package fpadd_pkg holds:
  - localparams EXP_W=8, FRAC_W=23, WORD_W=28, GUARD_W=2, EXP_SPECIAL=8'hFF.
  - typedef of the 28-bit extended word.
  - the state enum.
- One sub-module, align_shifter: combinational right shift of [25:0] by 0..SHIFT_STEP with a sticky OR output. It is instantiated once, on the small word.

## Test plan
- a=b=32'h3F800000 → 2 cycles; fra_a=fra_b=28'h2000000, exp_common=8'h7F, special=0.
- a=32'hC0400000, b=32'h3F800000, SHIFT_STEP=1 → 3 cycles; fra_a=28'hB000000, fra_b=28'h1000000, exp_common=8'h80.
- a=32'h3F800000, b=32'h33800001 (d=24), SHIFT_STEP=1 → 26 cycles; fra_b=28'h0000003 with UNPACK_STICKY_EN, 28'h0000002 without. Repeat with SHIFT_STEP=8 → 5 cycles, same values.
- a=32'h3F800000, b=32'h00800000 (d=126) → 2 cycles; fra_b=28'h0000001 with sticky, 0 without. a=32'h7F800000 → special=1, 2 cycles.
- Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, a pulsed in_valid is ignored. Release → handshake completes, next operands accepted on the following cycle.
- Deassert res during ALIGN → out_valid=0, all outputs 0, in_ready=1 immediately. A new transaction after reset release completes normally.

Source files
------------

// File: rtl/fpadd_pkg.sv
// Shared floating-point adder definitions: field widths, the 28-bit extended word and the stage FSM states.
// Build option: UNPACK_STICKY_EN folds shifted-out bits into bit [0] of the aligned word.
package fpadd_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int WORD_W  = 28;
  localparam int GUARD_W = 2;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

`ifdef UNPACK_STICKY_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  // [27] sign, [26] reserved carry, [25] hidden, [24:2] fraction, [1:0] guard
  typedef logic [WORD_W-1:0] ext_word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UNPACK = 2'd1,
    ST_ALIGN  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Zero exponent flushes the magnitude to zero but keeps the sign.
  function automatic ext_word_t unpack_word(input logic [31:0] op);
    ext_word_t w;
    if (op[30:23] != '0) w = {op[31], 1'b0, 1'b1, op[FRAC_W-1:0], {GUARD_W{1'b0}}};
    else                 w = {op[31], {(WORD_W-1){1'b0}}};
    return w;
  endfunction

endpackage

// File: rtl/operand_unpack_align_if.sv
// Operand/result bus of the adder front end. Both sides use valid/ready: a beat transfers
// on a rising edge where valid and ready are both high; the sender holds its payload stable until then.
interface operand_unpack_align_if;
  import fpadd_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          op_a;
  logic [31:0]          op_b;
  logic                 out_valid;
  logic                 out_ready;
  ext_word_t            fra_a;
  ext_word_t            fra_b;
  logic [EXP_W-1:0]     exp_common;
  logic                 special;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, fra_a, fra_b, exp_common, special
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, fra_a, fra_b, exp_common, special
  );
endinterface

// File: rtl/operand_unpack_align_shifter.sv
// Combinational right shift of a 26-bit magnitude by 0..MAX_SHIFT, reporting whether any set bit fell off.
module align_shifter #(
  parameter  int MAX_SHIFT = 1,
  localparam int AMT_W     = $clog2(MAX_SHIFT + 1)
) (
  input  logic [25:0]      mag_i,
  input  logic [AMT_W-1:0] amt_i,
  output logic [25:0]      mag_o,
  output logic             sticky_o
);

  logic [25:0] lost_mask;

  always_comb begin
    lost_mask = (26'(1) << amt_i) - 26'(1);
    mag_o     = mag_i >> amt_i;
    sticky_o  = |(mag_i & lost_mask);
  end

endmodule

// File: rtl/operand_unpack_align.sv
// Adder front end: unpack two single-precision operands and align the smaller-exponent one to the larger.
// Build option: UNPACK_STICKY_EN keeps a sticky bit in [0] of the shifted word instead of truncating.
module operand_unpack_align
  import fpadd_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic                 clk,
  input  logic                 res,
  operand_unpack_align_if.slave bus,
  output state_e               dbg_state_o
);

  localparam int AMT_W = $clog2(SHIFT_STEP + 1);
  localparam int REM_W = 5;

  state_e           state_q, state_d;
  logic [31:0]      op_a_q, op_a_d, op_b_q, op_b_d;
  ext_word_t        fra_a_q, fra_a_d, fra_b_q, fra_b_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             special_q, special_d;
  logic             small_b_q, small_b_d;
  logic [REM_W-1:0] rem_q, rem_d;

  logic [EXP_W-1:0] ea, eb, d_exp;
  ext_word_t        word_a, word_b, small_w, shifted_w;
  logic [AMT_W-1:0] amt;
  logic [25:0]      sh_mag;
  logic             sh_sticky, spec_in;

  assign ea      = op_a_q[30:23];
  assign eb      = op_b_q[30:23];
  assign d_exp   = (ea > eb) ? ea - eb : eb - ea;
  assign word_a  = unpack_word(op_a_q);
  assign word_b  = unpack_word(op_b_q);
  assign spec_in = (ea == EXP_SPECIAL) || (eb == EXP_SPECIAL);
  assign small_w = small_b_q ? fra_b_q : fra_a_q;
  assign amt     = (rem_q < REM_W'(SHIFT_STEP)) ? AMT_W'(rem_q) : AMT_W'(SHIFT_STEP);

  align_shifter #(.MAX_SHIFT(SHIFT_STEP)) u_shifter (
    .mag_i    (small_w[25:0]),
    .amt_i    (amt),
    .mag_o    (sh_mag),
    .sticky_o (sh_sticky)
  );

  // Sign and the reserved carry bit pass through; sticky folds into the LSB.
  assign shifted_w = {small_w[27:26], sh_mag[25:1], sh_mag[0] | (STICKY_EN & sh_sticky)};

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    fra_a_d   = fra_a_q;
    fra_b_d   = fra_b_q;
    exp_d     = exp_q;
    special_d = special_q;
    small_b_d = small_b_q;
    rem_d     = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_a_d  = bus.op_a;
          op_b_d  = bus.op_b;
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        fra_a_d   = word_a;
        fra_b_d   = word_b;
        exp_d     = (ea >= eb) ? ea : eb;
        special_d = spec_in;
        small_b_d = (ea > eb);
        rem_d     = '0;
        state_d   = ST_DONE;
        if (!spec_in && d_exp != '0) begin
          // Shifting 26+ places empties the magnitude; only the sticky summary can survive.
          if (d_exp >= 8'd26) begin
            if (ea > eb) fra_b_d = {word_b[27:26], 25'b0, STICKY_EN & (|word_b[25:0])};
            else         fra_a_d = {word_a[27:26], 25'b0, STICKY_EN & (|word_a[25:0])};
          end else begin
            rem_d   = d_exp[REM_W-1:0];
            state_d = ST_ALIGN;
          end
        end
      end
      ST_ALIGN: begin
        if (small_b_q) fra_b_d = shifted_w;
        else           fra_a_d = shifted_w;
        rem_d = rem_q - REM_W'(amt);
        if (rem_q == REM_W'(amt)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= ST_IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      fra_a_q   <= '0;
      fra_b_q   <= '0;
      exp_q     <= '0;
      special_q <= 1'b0;
      small_b_q <= 1'b0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      fra_a_q   <= fra_a_d;
      fra_b_q   <= fra_b_d;
      exp_q     <= exp_d;
      special_q <= special_d;
      small_b_q <= small_b_d;
      rem_q     <= rem_d;
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.fra_a      = fra_a_q;
  assign bus.fra_b      = fra_b_q;
  assign bus.exp_common = exp_q;
  assign bus.special    = special_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_operand_unpack_align.sv
// Bench for operand_unpack_align: directed and random operands, arithmetic reference model,
// expected-queue scoreboard with a separate output monitor.
module tb_operand_unpack_align;
  import fpadd_pkg::*;

  localparam int SHIFT_STEP = 1;
`ifdef UNPACK_STICKY_EN
  localparam bit MODEL_STICKY = 1'b1;
`else
  localparam bit MODEL_STICKY = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   res = 1'b0;
  state_e dbg_state;
  int     cyc = 0;

  operand_unpack_align_if bus ();

  operand_unpack_align #(.SHIFT_STEP(SHIFT_STEP)) dut (
    .clk         (clk),
    .res         (res),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {fra_a, fra_b, exp_common, special, latency}
  logic [72:0] exp_q[$];
  int          acc_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ready_mode = 0;   // 0 random, 1 held low, 2 held high
  logic        prev_v;
  logic [72:0] cur;
  int          cur_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [64:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            output int lat);
    longint ma, mb, sm, lost, p;
    int ea, eb, d;
    bit spc;
    logic [7:0] e;
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    ma  = (ea != 0) ? (((longint'(1) << 23) + longint'(a[22:0])) * 4) : 0;
    mb  = (eb != 0) ? (((longint'(1) << 23) + longint'(b[22:0])) * 4) : 0;
    spc = (ea == 255) || (eb == 255);
    d   = (ea > eb) ? ea - eb : eb - ea;
    e   = 8'((ea > eb) ? ea : eb);
    lat = 2;
    if (!spc && d != 0) begin
      sm = (ea < eb) ? ma : mb;
      if (d >= 26) begin
        sm = (MODEL_STICKY && sm != 0) ? 1 : 0;
      end else begin
        p    = longint'(1) << d;
        lost = sm % p;
        sm   = sm / p;
        if (MODEL_STICKY && lost != 0) sm = sm | 1;
        lat  = 2 + (d + SHIFT_STEP - 1) / SHIFT_STEP;
      end
      if (ea < eb) ma = sm;
      else         mb = sm;
    end
    return {a[31], 1'b0, ma[25:0], b[31], 1'b0, mb[25:0], e, spc};
  endfunction

  // driver: present operands until accepted; track=0 issues a transaction that will be aborted
  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit track);
    int g;
    int lat;
    logic [64:0] m;
    g = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    while (!bus.in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'd1, 32'd0);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (track) begin
      m = ref_model(a, b, lat);
      exp_q.push_back({m, 8'(lat)});
      acc_q.push_back(cyc);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0 || bus.out_valid) check("drain_timeout", 32'd1, 32'd0);
  endtask

  function automatic logic [31:0] rand_op(input int e_ref, input bit rel);
    int e;
    int sel;
    sel = int'($urandom_range(0, 9));
    if (rel)           e = e_ref + int'($urandom_range(0, 60)) - 30;
    else if (sel == 0) e = 0;
    else if (sel == 1) e = 255;
    else               e = int'($urandom_range(1, 254));
    if (e < 0)   e = 0;
    if (e > 255) e = 255;
    return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
  endfunction

  // out_ready driver, updated just after each rising edge
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        1:       bus.out_ready = 1'b0;
        2:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: pop on each new result, then require the outputs to stay put while out_valid is high
  initial begin
    prev_v  = 1'b0;
    cur     = '0;
    cur_acc = 0;
    forever begin
      @(negedge clk);
      if (!res) begin
        prev_v = 1'b0;
        continue;
      end
      if (bus.out_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
          cur = '0;
        end else begin
          cur     = exp_q.pop_front();
          cur_acc = acc_q.pop_front();
          check("latency", 32'(cyc - cur_acc + 1), 32'(cur[7:0]));
        end
      end
      if (bus.out_valid) begin
        check("fra_a", 32'(bus.fra_a), 32'(cur[72:45]));
        check("fra_b", 32'(bus.fra_b), 32'(cur[44:17]));
        check("exp_common", 32'(bus.exp_common), 32'(cur[16:9]));
        check("special", 32'(bus.special), 32'(cur[8]));
        check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      end
      prev_v = bus.out_valid;
    end
  end

  logic [31:0] dir_a[8] = '{32'h3F800000, 32'hC0400000, 32'h3F800000, 32'h3F800000,
                            32'h7F800000, 32'h00000000, 32'h33800001, 32'h3F800000};
  logic [31:0] dir_b[8] = '{32'h3F800000, 32'h3F800000, 32'h33800001, 32'h00800000,
                            32'h3F800000, 32'h80000000, 32'h3F800000, 32'h3E000001};

  initial begin
    int g;
    logic [31:0] a;
    bus.in_valid = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;

    // reset state, sampled while held and just after release
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_fra_a", 32'(bus.fra_a), 32'd0);
    check("rst_fra_b", 32'(bus.fra_b), 32'd0);
    check("rst_exp", 32'(bus.exp_common), 32'd0);
    check("rst_special", 32'(bus.special), 32'd0);
    res = 1'b1;
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // directed operands, including a known-constant spot check
    ready_mode = 2;
    for (int i = 0; i < 8; i++) send(dir_a[i], dir_b[i], 1'b1);
    drain();
    ready_mode = 0;

    // hold the result for 5 cycles; a stray in_valid pulse must be ignored
    ready_mode = 1;
    @(negedge clk);
    send(32'h3F800000, 32'h40000000, 1'b1);
    g = 0;
    while (!bus.out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("hold_reached_done", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_state", 32'(dbg_state), 32'(ST_DONE));
      bus.in_valid = (i == 1);
      bus.op_a     = 32'h41200000;
      bus.op_b     = 32'h3F800000;
    end
    bus.in_valid = 1'b0;
    ready_mode   = 2;
    g = 0;
    while (bus.out_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    send(32'h40400000, 32'h3F800000, 1'b1);
    drain();

    // reset while aligning aborts the transaction
    send(32'h3F800000, 32'h33800001, 1'b0);
    repeat (2) @(posedge clk);
    check("pre_abort_state", 32'(dbg_state), 32'(ST_ALIGN));
    #1;
    res = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_fra_a", 32'(bus.fra_a), 32'd0);
    check("abort_fra_b", 32'(bus.fra_b), 32'd0);
    check("abort_exp", 32'(bus.exp_common), 32'd0);
    check("abort_special", 32'(bus.special), 32'd0);
    @(negedge clk);
    res = 1'b1;
    send(32'h3F800000, 32'h33800001, 1'b1);
    drain();

    // randomized operands with random downstream backpressure
    ready_mode = 0;
    for (int i = 0; i < 150; i++) begin
      a = rand_op(0, 1'b0);
      send(a, rand_op(int'(a[30:23]), ($urandom_range(0, 3) != 0)), 1'b1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
